// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and defaults for the instruction fetch unit.
//   fetch_state_t  FSM encoding (FETCH/LOAD/HOLD)
//   pc_ctrl_t      control bundle from the fetch FSM to pc_reg
//   DEF_RESET_PC   default PC loaded on reset
//   DEF_PC_STEP    default sequential increment in bytes
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0040_0000;
    localparam int unsigned DEF_PC_STEP  = 4;

    typedef struct packed {
        logic        inc;     // advance by PC_STEP
        logic        load;    // take target (wins over inc)
        logic [31:0] target;  // raw redirect target, aligned inside pc_reg
    } pc_ctrl_t;

    // Word alignment: low two address bits are dropped, never trapped.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// pc_reg: program counter register.
//   clk, rst   clock and synchronous active-high reset
//   ctrl       inc / load / target from the fetch FSM
//   pc         current PC (registered, drives imem_addr directly)
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  pc_ctrl_t    ctrl,
    output logic [31:0] pc
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (ctrl.load)
            pc <= align_word(ctrl.target);
        else if (ctrl.inc)
            pc <= pc + STEP;  // wraps modulo 2^32
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one instruction word per decoder request.
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_addr       registered request to instruction memory
//   imem_ack/imem_rdata      memory response
//   ir_ena/ir_data           one-cycle IR load strobe and the word to load
//   next_req                 decoder wants the next instruction
//   redirect/redirect_pc     taken branch/jump and its target
//   pc_out                   PC of the instruction held in IR
//   busy                     high unless idle in HOLD
//   addr_err                 misaligned redirect, same cycle as the redirect
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_ena,
    output logic [31:0] ir_data,
    input  logic        next_req,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic        busy,
    output logic        addr_err
);

    fetch_state_t state, state_nxt;
    logic         squash, squash_nxt;
    logic         ld_ir;
    logic [31:0]  pc;
    pc_ctrl_t     pc_ctrl;

    // Redirect is accepted in every state and always overrides the increment.
    assign pc_ctrl.load   = redirect;
    assign pc_ctrl.inc    = (state == LOAD);
    assign pc_ctrl.target = redirect_pc;

    pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .ctrl (pc_ctrl),
        .pc   (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            squash  <= 1'b0;
            ir_data <= '0;
            pc_out  <= RESET_PC;
        end else begin
            state  <= state_nxt;
            squash <= squash_nxt;
            if (ld_ir)
                ir_data <= imem_rdata;
            if (state == LOAD)
                pc_out <= pc;
        end
    end

    always_comb begin
        state_nxt  = state;
        squash_nxt = squash;
        ld_ir      = 1'b0;
        case (state)
            FETCH: begin
                if (redirect) begin
                    // Outstanding request now targets a dead address; its
                    // ack (if not returning right now) must be dropped.
                    squash_nxt = ~imem_ack;
                end else if (imem_ack) begin
                    if (squash) begin
                        squash_nxt = 1'b0;
                    end else begin
                        ld_ir     = 1'b1;
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD:    state_nxt = redirect ? FETCH : HOLD;
            HOLD:    if (redirect || next_req) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // Request and address come straight from flops: no path from imem_ack.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign ir_ena    = (state == LOAD) && !rst;
    assign busy      = (state != HOLD);
    assign addr_err  = !rst && redirect && (redirect_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] R = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst, imem_ack, next_req, redirect;
    logic [31:0] imem_rdata, redirect_pc;
    logic        imem_req, ir_ena, busy, addr_err;
    logic [31:0] imem_addr, ir_data, pc_out;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir_ena(ir_ena), .ir_data(ir_data),
        .next_req(next_req), .redirect(redirect), .redirect_pc(redirect_pc),
        .pc_out(pc_out), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ack;
        logic [31:0] rdata;
        logic        nreq, redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ena;
        logic [31:0] e_ird, e_pco;
        logic        e_err, e_busy;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0, n_pass = 0;

    function automatic vec_t v(input logic r, a, input logic [31:0] d,
                               input logic n, rd, input logic [31:0] rp,
                               input logic eq, input logic [31:0] ea,
                               input logic ee, input logic [31:0] ei, ep,
                               input logic er, eb);
        vec_t t;
        t.rst = r; t.ack = a; t.rdata = d; t.nreq = n; t.redir = rd; t.rpc = rp;
        t.e_req = eq; t.e_addr = ea; t.e_ena = ee; t.e_ird = ei; t.e_pco = ep;
        t.e_err = er; t.e_busy = eb;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic eq, input logic [31:0] ea,
                           input logic ee, input logic [31:0] ei, ep,
                           input logic er, eb);
        chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, eq});
        chk({tag, ".addr"},  imem_addr, ea);
        chk({tag, ".ena"},   {31'd0, ir_ena}, {31'd0, ee});
        chk({tag, ".ird"},   ir_data, ei);
        chk({tag, ".pco"},   pc_out, ep);
        chk({tag, ".err"},   {31'd0, addr_err}, {31'd0, er});
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, eb});
    endtask

    // Reference model: what the unit is doing (waiting for a word, presenting
    // one to IR, or idle), the PC it will fetch, and whether the next ack is stale.
    localparam int M_WAIT = 0, M_LOAD = 1, M_IDLE = 2;
    int          m_mode;
    logic [31:0] m_pc, m_pco, m_ir;
    bit          m_stale;

    task automatic model_step();
        logic [31:0] tgt;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (rst) begin
            m_mode = M_WAIT; m_pc = R; m_pco = R; m_ir = 0; m_stale = 0;
        end else if (m_mode == M_WAIT) begin
            if (redirect) begin
                m_pc = tgt; m_stale = !imem_ack;
            end else if (imem_ack) begin
                if (m_stale) m_stale = 0;
                else begin m_ir = imem_rdata; m_mode = M_LOAD; end
            end
        end else if (m_mode == M_LOAD) begin
            m_pco = m_pc;
            m_pc  = redirect ? tgt : m_pc + 32'd4;
            m_mode = redirect ? M_WAIT : M_IDLE;
        end else begin
            if (redirect) m_pc = tgt;
            if (redirect || next_req) m_mode = M_WAIT;
        end
    endtask

    initial begin
        int lat;
        bit found;
        logic [31:0] tmp;

        rst = 1; imem_ack = 0; imem_rdata = 0; next_req = 0; redirect = 0; redirect_pc = 0;
        repeat (2) @(posedge clk);

        //              rst ack rdata         nrq rdr rpc            req addr          ena ird           pco           err busy
        tbl.push_back(v(1, 1, 32'hDEAD_BEEF, 0, 0, 0,              1, R,            0, 0,            R,            0, 1));
        tbl.push_back(v(0, 1, 32'h2008_0001, 0, 0, 0,              1, R,            0, 0,            R,            0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              0, R,            1, 32'h2008_0001, R,           0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              0, R+4,          0, 32'h2008_0001, R,           0, 0));
        tbl.push_back(v(0, 0, 0,             1, 0, 0,              0, R+4,          0, 32'h2008_0001, R,           0, 0));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, R+4,          0, 32'h2008_0001, R,           0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, R+4,          0, 32'h2008_0001, R,           0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, R+4,          0, 32'h2008_0001, R,           0, 1));
        tbl.push_back(v(0, 1, 32'h1111_0004, 0, 0, 0,              1, R+4,          0, 32'h2008_0001, R,           0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              0, R+4,          1, 32'h1111_0004, R,           0, 1));
        tbl.push_back(v(0, 0, 0,             1, 0, 0,              0, R+8,          0, 32'h1111_0004, R+4,         0, 0));
        tbl.push_back(v(0, 0, 0,             0, 1, 32'h0040_0100,  1, R+8,          0, 32'h1111_0004, R+4,         0, 1));
        tbl.push_back(v(0, 1, 32'hBAD0_0000, 0, 0, 0,              1, 32'h0040_0100, 0, 32'h1111_0004, R+4,        0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, 32'h0040_0100, 0, 32'h1111_0004, R+4,        0, 1));
        tbl.push_back(v(0, 1, 32'h3333_0100, 0, 0, 0,              1, 32'h0040_0100, 0, 32'h1111_0004, R+4,        0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              0, 32'h0040_0100, 1, 32'h3333_0100, R+4,        0, 1));
        tbl.push_back(v(0, 0, 0,             1, 1, 32'h0040_0102,  0, 32'h0040_0104, 0, 32'h3333_0100, 32'h0040_0100, 1, 0));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, 32'h0040_0100, 0, 32'h3333_0100, 32'h0040_0100, 0, 1));
        tbl.push_back(v(1, 1, 32'h4444_4444, 0, 0, 0,              1, 32'h0040_0100, 0, 32'h3333_0100, 32'h0040_0100, 0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, R,            0, 0,            R,            0, 1));
        tbl.push_back(v(0, 1, 32'h5555_5555, 0, 1, 32'h0040_0200,  1, R,            0, 0,            R,            0, 1));
        tbl.push_back(v(0, 1, 32'h6666_0200, 0, 0, 0,              1, 32'h0040_0200, 0, 0,           R,            0, 1));
        tbl.push_back(v(0, 0, 0,             0, 1, 32'hFFFF_FFFC,  0, 32'h0040_0200, 1, 32'h6666_0200, R,          0, 1));
        tbl.push_back(v(0, 1, 32'h7777_7777, 0, 0, 0,              1, 32'hFFFF_FFFC, 0, 32'h6666_0200, 32'h0040_0200, 0, 1));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              0, 32'hFFFF_FFFC, 1, 32'h7777_7777, 32'h0040_0200, 0, 1));
        tbl.push_back(v(0, 0, 0,             1, 0, 0,              0, 32'h0000_0000, 0, 32'h7777_7777, 32'hFFFF_FFFC, 0, 0));
        tbl.push_back(v(0, 0, 0,             0, 0, 0,              1, 32'h0000_0000, 0, 32'h7777_7777, 32'hFFFF_FFFC, 0, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rdata;
            next_req = tbl[i].nreq; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_ena,
                    tbl[i].e_ird, tbl[i].e_pco, tbl[i].e_err, tbl[i].e_busy);
        end

        // Latency from a HOLD-state next_req to ir_ena with zero-wait memory.
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst = 0; imem_ack = 1; imem_rdata = 32'hCAFE_0003; next_req = 0; redirect = 0;
            #1;
            if (!busy) begin found = 1; break; end
        end
        chk("reach_hold", {31'd0, found}, 32'd1);
        next_req = 1;
        lat = 1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            next_req = 0; imem_ack = 1;
            #1;
            lat++;
            if (ir_ena) begin found = 1; break; end
        end
        chk("lat_seen", {31'd0, found}, 32'd1);
        chk("latency", lat, 32'd3);
        chk("lat_ird", ir_data, 32'hCAFE_0003);

        // Randomized run against the reference model.
        @(negedge clk);
        rst = 1; imem_ack = 0; next_req = 0; redirect = 0;
        #1;
        model_step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) == 0);
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            next_req   = ($urandom_range(0, 2) == 0);
            redirect   = ($urandom_range(0, 9) == 0);
            tmp = $urandom;
            if ($urandom_range(0, 3) != 0) tmp[1:0] = 2'b00;
            redirect_pc = tmp;
            #1;
            chk_all($sformatf("rnd%0d", i), m_mode == M_WAIT, m_pc,
                    (m_mode == M_LOAD) && !rst, m_ir, m_pco,
                    !rst && redirect && (redirect_pc[1:0] != 2'b00),
                    m_mode != M_IDLE);
            model_step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
